// File: rtl/reduce_if.sv
// Contribution/emission handshake bundle for reduce_ctrl.
// The slave modport is the reduction controller; the master modport is its environment.
interface reduce_if #(
   parameter int unsigned FlitWidth     = 73,
   parameter int unsigned ChildrenWidth = 3
);
   logic                               in_valid;
   logic                               in_ready;
   logic [ChildrenWidth+FlitWidth-1:0] in_packet;
   logic                               out_valid;
   logic                               out_ready;
   logic [FlitWidth-1:0]               out_packet;

   modport slave (
      input  in_valid, in_packet, out_ready,
      output in_ready, out_valid, out_packet
   );

   modport master (
      output in_valid, in_packet, out_ready,
      input  in_ready, out_valid, out_packet
   );
endinterface

// File: rtl/reduce_ctrl.sv
// In-network reduction table: folds child contributions per context and emits one flit each.
// Optional idle-timeout forced emission is enabled by defining REDUCE_CTRL_TIMEOUT_EN.
module reduce_ctrl #(
   parameter int unsigned NUM_ENTRIES   = 4,
   parameter int unsigned FlitWidth     = 73,
   parameter int unsigned ChildrenWidth = 3,
   parameter int unsigned TIMEOUT       = 255
) (
   input  logic     clk,
   input  logic     rst,
   reduce_if.slave  bus,
   output logic     busy,
   output logic     timeout_flag
);
   localparam int unsigned IdxW     = (NUM_ENTRIES > 1) ? $clog2(NUM_ENTRIES) : 1;
   localparam int unsigned PayloadW = 32;
   localparam int unsigned HdrW     = FlitWidth - PayloadW - 1;
   localparam int unsigned CtxLsb   = 46;
   localparam int unsigned ValidBit = FlitWidth - 1;

   typedef enum logic [1:0] {IDLE, ACCUM, PENDING} entry_state_e;

   entry_state_e             state_q [NUM_ENTRIES];
   logic [HdrW-1:0]          hdr_q   [NUM_ENTRIES];
   logic [PayloadW-1:0]      acc_q   [NUM_ENTRIES];
   logic [ChildrenWidth-1:0] wait_q  [NUM_ENTRIES];
   logic [IdxW-1:0]          rr_q;
   logic                     out_valid_q;
   logic [FlitWidth-1:0]     out_packet_q;

   logic [FlitWidth-1:0]     in_flit;
   logic [ChildrenWidth-1:0] in_children;
   logic [IdxW-1:0]          in_idx;
   logic                     accept;
   logic                     load;
   logic                     sel_found;
   logic [IdxW-1:0]          sel_idx;

   function automatic logic [PayloadW-1:0] apply_op(input logic [3:0]          op,
                                                    input logic [PayloadW-1:0] a,
                                                    input logic [PayloadW-1:0] b);
      case (op)
         4'd1:    apply_op = (a > b) ? a : b;
         4'd2:    apply_op = (a < b) ? a : b;
         4'd3:    apply_op = a ^ b;
         default: apply_op = a + b;
      endcase
   endfunction

   assign in_flit     = bus.in_packet[FlitWidth-1:0];
   assign in_children = bus.in_packet[FlitWidth +: ChildrenWidth];
   assign in_idx      = in_flit[CtxLsb +: IdxW];

   // A pending entry blocks new contributions until the output register takes it.
   assign bus.in_ready = (state_q[in_idx] != PENDING);
   assign accept       = bus.in_valid && bus.in_ready && in_flit[ValidBit];

   // Round-robin pick among pending entries, starting after the last emitted one.
   always_comb begin
      int unsigned     j;
      logic [IdxW-1:0] cand;
      j         = 0;
      cand      = '0;
      sel_found = 1'b0;
      sel_idx   = '0;
      for (int unsigned k = 0; k < NUM_ENTRIES; k++) begin
         j    = (32'(rr_q) + k) % NUM_ENTRIES;
         cand = IdxW'(j);
         if (!sel_found && state_q[cand] == PENDING) begin
            sel_found = 1'b1;
            sel_idx   = cand;
         end
      end
   end

   assign load = sel_found && (!out_valid_q || bus.out_ready);

`ifdef REDUCE_CTRL_TIMEOUT_EN
   localparam int unsigned CntW = $clog2(TIMEOUT + 1);

   logic [CntW-1:0]        idle_q [NUM_ENTRIES];
   logic [NUM_ENTRIES-1:0] expire_c;
   logic                   timeout_q;

   always_comb begin
      expire_c = '0;
      for (int e = 0; e < NUM_ENTRIES; e++) begin
         expire_c[e] = (state_q[e] == ACCUM) && (idle_q[e] == CntW'(TIMEOUT - 1)) &&
                       !(accept && in_idx == IdxW'(e));
      end
   end

   // Per-entry count of consecutive cycles spent in ACCUM without a contribution.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int e = 0; e < NUM_ENTRIES; e++) idle_q[e] <= '0;
         timeout_q <= 1'b0;
      end else begin
         for (int e = 0; e < NUM_ENTRIES; e++) begin
            if ((accept && in_idx == IdxW'(e)) || state_q[e] != ACCUM) idle_q[e] <= '0;
            else                                                        idle_q[e] <= idle_q[e] + CntW'(1);
         end
         if (|expire_c) timeout_q <= 1'b1;
      end
   end

   assign timeout_flag = timeout_q;
`else
   // TIMEOUT has no effect in this build; ACCUM entries wait indefinitely.
   if (TIMEOUT == 0) begin : g_timeout_unused
   end
   assign timeout_flag = 1'b0;
`endif

   // Entry table: load on first contribution, fold later ones, free on emission.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int e = 0; e < NUM_ENTRIES; e++) begin
            state_q[e] <= IDLE;
            hdr_q[e]   <= '0;
            acc_q[e]   <= '0;
            wait_q[e]  <= '0;
         end
      end else begin
         for (int e = 0; e < NUM_ENTRIES; e++) begin
            if (load && sel_idx == IdxW'(e)) begin
               state_q[e] <= IDLE;
            end else if (accept && in_idx == IdxW'(e)) begin
               case (state_q[e])
                  IDLE: begin
                     hdr_q[e]   <= in_flit[FlitWidth-2:PayloadW];
                     acc_q[e]   <= in_flit[PayloadW-1:0];
                     wait_q[e]  <= in_children;
                     state_q[e] <= (in_children == '0) ? PENDING : ACCUM;
                  end
                  ACCUM: begin
                     acc_q[e]  <= apply_op(hdr_q[e][3:0], acc_q[e], in_flit[PayloadW-1:0]);
                     wait_q[e] <= wait_q[e] - ChildrenWidth'(1);
                     if (wait_q[e] == ChildrenWidth'(1)) state_q[e] <= PENDING;
                  end
                  default: ;
               endcase
`ifdef REDUCE_CTRL_TIMEOUT_EN
            end else if (expire_c[e]) begin
               state_q[e] <= PENDING;
`endif
            end
         end
      end
   end

   // Output register refills in the same cycle it drains, giving one flit per cycle.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         out_valid_q  <= 1'b0;
         out_packet_q <= '0;
         rr_q         <= '0;
      end else if (load) begin
         out_valid_q  <= 1'b1;
         out_packet_q <= FlitWidth'({1'b1, hdr_q[sel_idx], acc_q[sel_idx]});
         rr_q         <= (32'(sel_idx) == NUM_ENTRIES - 1) ? '0 : sel_idx + IdxW'(1);
      end else if (bus.out_ready) begin
         out_valid_q <= 1'b0;
      end
   end

   assign bus.out_valid  = out_valid_q;
   assign bus.out_packet = out_packet_q;

   always_comb begin
      busy = out_valid_q;
      for (int e = 0; e < NUM_ENTRIES; e++) begin
         if (state_q[e] != IDLE) busy = 1'b1;
      end
   end
endmodule

// File: tb/tb_reduce_ctrl.sv
// Directed and randomized checks of reduce_ctrl against a payload-list reference model.
// Timeout-specific checks follow REDUCE_CTRL_TIMEOUT_EN.
module tb_reduce_ctrl;
   localparam int unsigned NE = 4;

   logic clk = 1'b0;
   logic rst;
   logic busy;
   logic timeout_flag;

   always #5 clk = ~clk;

   reduce_if #(.FlitWidth(73), .ChildrenWidth(3)) bus ();

   reduce_ctrl #(
      .NUM_ENTRIES(NE), .FlitWidth(73), .ChildrenWidth(3), .TIMEOUT(8)
   ) dut (
      .clk(clk), .rst(rst), .bus(bus), .busy(busy), .timeout_flag(timeout_flag)
   );

   int n_cmp = 0;
   int n_err = 0;
   int n_emit = 0;

   // Reference model: per entry, the list of payloads received in the current reduction.
   int unsigned  m_cnt   [NE];
   logic [75:0]  m_first [NE];
   logic [31:0]  m_pl    [NE][8];
   logic [72:0]  exp_q   [$];
   logic         hold_q;
   logic [72:0]  hold_pkt;
   logic [75:0]  f0, f1, f2, f3;
   logic [75:0]  rp;

   function automatic logic [75:0] mk(input int unsigned ch, input int unsigned ctx,
                                      input int unsigned op, input logic [31:0] pl);
      logic [75:0] p;
      p          = '0;
      p[75:73]   = 3'(ch);
      p[72]      = 1'b1;
      p[71:54]   = 18'h2B3C5;
      p[53:46]   = 8'(ctx);
      p[45:36]   = 10'h155;
      p[35:32]   = 4'(op);
      p[31:0]    = pl;
      return p;
   endfunction

   function automatic logic [72:0] expo(input logic [75:0] first, input logic [31:0] pl);
      return {1'b1, first[71:32], pl};
   endfunction

   function automatic logic [31:0] fold(input int unsigned e);
      logic [31:0]     r;
      longint unsigned s;
      int unsigned     n;
      n = m_cnt[e];
      r = m_pl[e][0];
      s = 0;
      case (m_first[e][35:32])
         4'd1: for (int i = 0; i < n; i++) if (m_pl[e][i] > r) r = m_pl[e][i];
         4'd2: for (int i = 0; i < n; i++) if (m_pl[e][i] < r) r = m_pl[e][i];
         4'd3: begin
            r = 32'h0;
            for (int i = 0; i < n; i++) r = r ^ m_pl[e][i];
         end
         default: begin
            for (int i = 0; i < n; i++) s = s + 64'(m_pl[e][i]);
            r = s[31:0];
         end
      endcase
      return r;
   endfunction

   task automatic chk(input string tag, input logic [75:0] obs, input logic [75:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic send(input logic [75:0] p);
      int unsigned t;
      t             = 0;
      bus.in_packet = p;
      bus.in_valid  = 1'b1;
      @(negedge clk);
      while (!bus.in_ready && t < 40) begin
         t++;
         @(negedge clk);
      end
      chk("send_ready", 76'(bus.in_ready), 76'(1));
      @(posedge clk);
      #1;
      bus.in_valid = 1'b0;
   endtask

   task automatic reduce_chk(input string tag, input int unsigned ctx, input int unsigned op,
                             input int unsigned n, input logic [31:0] a, input logic [31:0] b,
                             input logic [31:0] c, input logic [31:0] exp);
      logic [75:0] f;
      f = mk(n - 1, ctx, op, a);
      send(f);
      if (n > 1) send(mk(n - 1, ctx, op, b));
      if (n > 2) send(mk(n - 1, ctx, op, c));
      chk({tag, "_early"}, 76'(bus.out_valid), 76'(0));
      tick();
      chk({tag, "_valid"}, 76'(bus.out_valid), 76'(1));
      chk(tag, 76'(bus.out_packet), 76'(expo(f, exp)));
      tick();
      chk({tag, "_once"}, 76'(bus.out_valid), 76'(0));
   endtask

   task automatic rand_sample();
      int unsigned e;
      int          found;
      logic [75:0] p;
      @(negedge clk);
      if (hold_q) chk("rand_hold", 76'({bus.out_valid, bus.out_packet}), 76'({1'b1, hold_pkt}));
      if (bus.out_valid && bus.out_ready) begin
         n_emit++;
         found = -1;
         foreach (exp_q[j]) if (found < 0 && exp_q[j][47:46] == bus.out_packet[47:46]) found = j;
         if (found >= 0) begin
            chk("rand_out", 76'(bus.out_packet), 76'(exp_q[found]));
            exp_q.delete(found);
         end else begin
            chk("rand_unexpected", 76'(bus.out_valid), 76'(0));
         end
      end
      hold_q   = bus.out_valid && !bus.out_ready;
      hold_pkt = bus.out_packet;
      p = bus.in_packet;
      e = 32'(p[47:46]);
      if (bus.in_valid && m_cnt[e] != 0) chk("rand_ready_accum", 76'(bus.in_ready), 76'(1));
      if (bus.in_valid && bus.in_ready && p[72]) begin
         if (m_cnt[e] == 0) m_first[e] = p;
         m_pl[e][m_cnt[e]] = p[31:0];
         m_cnt[e]++;
         if (m_cnt[e] == 32'(m_first[e][75:73]) + 1) begin
            exp_q.push_back(expo(m_first[e], fold(e)));
            m_cnt[e] = 0;
         end
      end
      @(posedge clk);
      #1;
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1);
   end

   initial begin
      rst           = 1'b1;
      bus.in_valid  = 1'b0;
      bus.in_packet = '0;
      bus.out_ready = 1'b0;
      hold_q        = 1'b0;
      hold_pkt      = '0;
      #12;
      chk("rst_out_valid", 76'(bus.out_valid), 76'(0));
      chk("rst_out_packet", 76'(bus.out_packet), 76'(0));
      chk("rst_busy", 76'(busy), 76'(0));
      chk("rst_timeout_flag", 76'(timeout_flag), 76'(0));
      chk("rst_in_ready", 76'(bus.in_ready), 76'(1));
      tick();
      rst = 1'b0;
      tick();

      bus.out_ready = 1'b1;
      reduce_chk("sum_5_7_9", 1, 0, 3, 32'd5, 32'd7, 32'd9, 32'd21);
      reduce_chk("pass_max", 0, 0, 1, 32'hFFFF_FFFF, 32'h0, 32'h0, 32'hFFFF_FFFF);
      reduce_chk("add_wrap", 0, 0, 2, 32'hFFFF_FFFF, 32'd2, 32'h0, 32'd1);
      reduce_chk("op_max", 8'h46, 1, 3, 32'd3, 32'h8000_0000, 32'd2, 32'h8000_0000);
      reduce_chk("op_min", 3, 2, 3, 32'd3, 32'h8000_0000, 32'd2, 32'd2);
      reduce_chk("op_xor", 1, 3, 2, 32'hF0, 32'h0F, 32'h0, 32'hFF);
      reduce_chk("op7_add", 2, 7, 2, 32'd10, 32'd20, 32'h0, 32'd30);

      // Four entries complete while downstream stalls.
      bus.out_ready = 1'b0;
      f0 = mk(0, 0, 0, 32'h100);
      f1 = mk(0, 1, 0, 32'h101);
      f2 = mk(0, 2, 0, 32'h102);
      f3 = mk(0, 3, 0, 32'h103);
      send(f0);
      send(f1);
      send(f2);
      send(f3);
      chk("stall_busy", 76'(busy), 76'(1));
      bus.in_packet = mk(0, 0, 0, 32'h0);
      #1;
      chk("stall_ready_ctx0", 76'(bus.in_ready), 76'(1));
      for (int i = 0; i < 10; i++) begin
         chk("stall_valid", 76'(bus.out_valid), 76'(1));
         chk("stall_hold", 76'(bus.out_packet), 76'(expo(f0, 32'h100)));
         for (int k = 1; k < 4; k++) begin
            bus.in_packet = mk(0, k, 0, 32'h0);
            #1;
            chk("stall_ready_blocked", 76'(bus.in_ready), 76'(0));
         end
         tick();
      end
      bus.out_ready = 1'b1;
      chk("order_0", 76'(bus.out_packet), 76'(expo(f0, 32'h100)));
      tick();
      chk("order_1_valid", 76'(bus.out_valid), 76'(1));
      chk("order_1", 76'(bus.out_packet), 76'(expo(f1, 32'h101)));
      tick();
      chk("order_2", 76'(bus.out_packet), 76'(expo(f2, 32'h102)));
      tick();
      chk("order_3", 76'(bus.out_packet), 76'(expo(f3, 32'h103)));
      tick();
      chk("order_end_valid", 76'(bus.out_valid), 76'(0));
      chk("order_end_busy", 76'(busy), 76'(0));

      // Reset in the middle of a reduction with a flit parked in the output register.
      bus.out_ready = 1'b0;
      send(mk(0, 2, 0, 32'hAB));
      send(mk(2, 1, 0, 32'd10));
      chk("mid_rst_pre_valid", 76'(bus.out_valid), 76'(1));
      #2;
      rst = 1'b1;
      #1;
      chk("mid_rst_valid", 76'(bus.out_valid), 76'(0));
      chk("mid_rst_packet", 76'(bus.out_packet), 76'(0));
      chk("mid_rst_busy", 76'(busy), 76'(0));
      tick();
      rst           = 1'b0;
      bus.out_ready = 1'b1;
      for (int i = 0; i < 5; i++) begin
         tick();
         chk("mid_rst_no_emit", 76'(bus.out_valid), 76'(0));
      end
      reduce_chk("post_rst_fresh", 1, 0, 1, 32'h1234, 32'h0, 32'h0, 32'h1234);

      // Reduction left short of contributions.
      f0 = mk(3, 3, 0, 32'h77);
      send(f0);
      chk("short_flag_start", 76'(timeout_flag), 76'(0));
`ifdef REDUCE_CTRL_TIMEOUT_EN
      for (int i = 1; i <= 8; i++) begin
         tick();
         chk("to_wait", 76'(bus.out_valid), 76'(0));
      end
      chk("to_flag_set", 76'(timeout_flag), 76'(1));
      tick();
      chk("to_emit_valid", 76'(bus.out_valid), 76'(1));
      chk("to_emit_packet", 76'(bus.out_packet), 76'(expo(f0, 32'h77)));
      tick();
      chk("to_flag_sticky", 76'(timeout_flag), 76'(1));
`else
      for (int i = 0; i < 20; i++) begin
         tick();
         chk("short_no_emit", 76'(bus.out_valid), 76'(0));
         chk("short_no_flag", 76'(timeout_flag), 76'(0));
      end
      chk("short_busy", 76'(busy), 76'(1));
`endif
      rst = 1'b1;
      tick();
      rst = 1'b0;
      chk("final_rst_flag", 76'(timeout_flag), 76'(0));
      chk("final_rst_busy", 76'(busy), 76'(0));

`ifndef REDUCE_CTRL_TIMEOUT_EN
      for (int e = 0; e < NE; e++) m_cnt[e] = 0;
      hold_q = 1'b0;
      for (int cyc = 0; cyc < 800; cyc++) begin
         case ($urandom_range(0, 3))
            0:       rp = mk($urandom_range(0, 3), $urandom_range(0, 255), $urandom_range(0, 6), 32'hFFFF_FFFF);
            1:       rp = mk($urandom_range(0, 3), $urandom_range(0, 255), $urandom_range(0, 6), 32'h0);
            default: rp = mk($urandom_range(0, 3), $urandom_range(0, 255), $urandom_range(0, 6), $urandom);
         endcase
         rp[71:54] = 18'($urandom);
         if ($urandom_range(0, 9) == 0) rp[72] = 1'b0;
         bus.in_packet = rp;
         bus.in_valid  = ($urandom_range(0, 9) < 7);
         bus.out_ready = ($urandom_range(0, 9) < 6);
         rand_sample();
      end
      bus.in_valid  = 1'b0;
      bus.out_ready = 1'b1;
      for (int cyc = 0; cyc < 20; cyc++) rand_sample();
      chk("rand_drained", 76'(exp_q.size()), 76'(0));
      chk("rand_emitted", 76'(n_emit > 20), 76'(1));
`endif

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end
endmodule
